// File: rtl/fir_out_stage_if.sv
// Handshake and status bundle for the FIR output stage.
// The slave modport is the stage's view; the master modport is the upstream/downstream view.
interface fir_out_stage_if #(
  parameter int DW = 32
);
  logic          in_valid;
  logic [DW-1:0] in_data;
  logic          clear;
  logic [6:0]    pkt_len;
  logic          out_ready;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic          out_last;
  logic          tx_valid;
  logic [9:0]    level;
  logic [15:0]   drop_cnt;

  modport slave (
    input  in_valid, in_data, clear, pkt_len, out_ready,
    output out_valid, out_data, out_last, tx_valid, level, drop_cnt
  );

  modport master (
    output in_valid, in_data, clear, pkt_len, out_ready,
    input  out_valid, out_data, out_last, tx_valid, level, drop_cnt
  );
endinterface

// File: rtl/fir_out_stage.sv
// FIR output stage: RAM FIFO with a registered head, packetiser and drop counter.
// Optional macro FIR_OUT_DROP_CNT_EN enables the drop counter; otherwise drop_cnt is tied to 0.
module fir_out_stage #(
  parameter int DEPTH = 512,
  parameter int DW    = 32
) (
  input  logic           clk,
  input  logic           rst_n,
  fir_out_stage_if.slave bus
);
  localparam int         AW         = $clog2(DEPTH);
  localparam logic [9:0] FULL_LEVEL = 10'(DEPTH);

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [9:0]    level_q, level_d;
  logic          out_valid_q, out_valid_d;
  logic [DW-1:0] out_data_q;
  logic [6:0]    pkt_cnt_q, pkt_cnt_d;
  logic [6:0]    len_m1_q, len_m1_d;

  logic          xfer, out_free, ram_empty, wr_accept;
  logic          wr_ram, load_ram, load_byp;
  logic [9:0]    ram_cnt;
  logic [6:0]    last_idx;

  // level counts the head register too, so the RAM never holds more than DEPTH-1
  // entries and the read and write pointers never collide while both are active.
  always_comb begin
    xfer      = out_valid_q & bus.out_ready & ~bus.clear;
    out_free  = ~out_valid_q | xfer;
    ram_cnt   = level_q - {9'd0, out_valid_q};
    ram_empty = (ram_cnt == 10'd0);
    wr_accept = bus.in_valid & ~bus.clear & ((level_q != FULL_LEVEL) | xfer);
    load_ram  = ~bus.clear & out_free & ~ram_empty;
    load_byp  = ~bus.clear & out_free & ram_empty & wr_accept;
    wr_ram    = wr_accept & ~load_byp;
    // pkt_len of 0 wraps to 127, i.e. a 128-sample packet
    last_idx  = (pkt_cnt_q == 7'd0) ? (bus.pkt_len - 7'd1) : len_m1_q;
  end

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    level_d     = level_q;
    out_valid_d = out_valid_q;
    pkt_cnt_d   = pkt_cnt_q;
    len_m1_d    = len_m1_q;
    if (bus.clear) begin
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      level_d     = 10'd0;
      out_valid_d = 1'b0;
      pkt_cnt_d   = 7'd0;
    end else begin
      if (wr_ram)   wr_ptr_d = wr_ptr_q + AW'(1);
      if (load_ram) rd_ptr_d = rd_ptr_q + AW'(1);
      if (out_free) out_valid_d = ~ram_empty | wr_accept;
      level_d = level_q + {9'd0, wr_accept} - {9'd0, xfer};
      if (xfer) begin
        if (pkt_cnt_q == 7'd0) len_m1_d = bus.pkt_len - 7'd1;
        pkt_cnt_d = (pkt_cnt_q == last_idx) ? 7'd0 : pkt_cnt_q + 7'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wr_ram) mem[wr_ptr_q] <= bus.in_data;
  end

  // Head register doubles as the RAM read register; an empty RAM is bypassed.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_data_q <= '0;
    end else if (load_ram) begin
      out_data_q <= mem[rd_ptr_q];
    end else if (load_byp) begin
      out_data_q <= bus.in_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= 10'd0;
      out_valid_q <= 1'b0;
      pkt_cnt_q   <= 7'd0;
      len_m1_q    <= 7'd0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
      out_valid_q <= out_valid_d;
      pkt_cnt_q   <= pkt_cnt_d;
      len_m1_q    <= len_m1_d;
    end
  end

`ifdef FIR_OUT_DROP_CNT_EN
  logic [15:0] drop_cnt_q;
  logic        drop;

  assign drop = bus.in_valid & ~bus.clear & (level_q == FULL_LEVEL) & ~xfer;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      drop_cnt_q <= 16'd0;
    end else if (drop && (drop_cnt_q != 16'hFFFF)) begin
      drop_cnt_q <= drop_cnt_q + 16'd1;
    end
  end

  assign bus.drop_cnt = drop_cnt_q;
`else
  assign bus.drop_cnt = 16'd0;
`endif

  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_last  = out_valid_q & (pkt_cnt_q == last_idx);
  assign bus.tx_valid  = xfer;
  assign bus.level     = level_q;
endmodule

// File: tb/tb_fir_out_stage.sv
// Directed self-checking bench for fir_out_stage (DEPTH=512, DW=32).
// Expected drop count follows FIR_OUT_DROP_CNT_EN.
module tb_fir_out_stage;
  logic clk = 1'b0;
  logic rst_n;
  int   n_assert = 0;
  int   n_fail   = 0;
  int   txc, lastc;

`ifdef FIR_OUT_DROP_CNT_EN
  localparam logic [15:0] DROP_EXP = 16'd2;
`else
  localparam logic [15:0] DROP_EXP = 16'd0;
`endif

  always #5 clk = ~clk;

  fir_out_stage_if #(.DW(32)) bus ();

  fir_out_stage #(.DEPTH(512), .DW(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = 32'd0;
    bus.clear     = 1'b0;
    bus.pkt_len   = 7'd1;
    bus.out_ready = 1'b1;
    tick();
    tick();
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_out_last",  32'(bus.out_last),  32'd0);
    chk("rst_tx_valid",  32'(bus.tx_valid),  32'd0);
    chk("rst_out_data",  bus.out_data,       32'd0);
    chk("rst_level",     32'(bus.level),     32'd0);
    chk("rst_drop_cnt",  32'(bus.drop_cnt),  32'd0);
    $display("step reset done");

    // single sample, one-cycle latency
    rst_n        = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_data  = 32'h0000_1234;
    #1;
    chk("single_pre_valid", 32'(bus.out_valid), 32'd0);
    tick();
    bus.in_valid = 1'b0;
    #1;
    chk("single_valid", 32'(bus.out_valid), 32'd1);
    chk("single_data",  bus.out_data,       32'h0000_1234);
    chk("single_tx",    32'(bus.tx_valid),  32'd1);
    chk("single_last",  32'(bus.out_last),  32'd1);
    chk("single_level", 32'(bus.level),     32'd1);
    $display("xfer single data=%0h last=%0b", bus.out_data, bus.out_last);
    tick();
    chk("single_empty_valid", 32'(bus.out_valid), 32'd0);
    chk("single_empty_level", 32'(bus.level),     32'd0);
    chk("single_empty_tx",    32'(bus.tx_valid),  32'd0);

    // pkt_len=4, 12 back-to-back samples
    bus.pkt_len = 7'd4;
    txc = 0;
    lastc = 0;
    for (int k = 0; k <= 12; k++) begin
      bus.in_valid = (k < 12);
      bus.in_data  = 32'(k + 1);
      #1;
      if (k > 0) begin
        chk("pkt4_data", bus.out_data,      32'(k));
        chk("pkt4_last", 32'(bus.out_last), 32'(k % 4 == 0));
        $display("xfer pkt4 t=%0d data=%0h last=%0b", k, bus.out_data, bus.out_last);
      end
      if (bus.tx_valid) txc++;
      if (bus.tx_valid && bus.out_last) lastc++;
      tick();
    end
    bus.in_valid = 1'b0;
    #1;
    chk("pkt4_tx_count",   32'(txc),            32'd12);
    chk("pkt4_last_count", 32'(lastc),          32'd3);
    chk("pkt4_end_valid",  32'(bus.out_valid),  32'd0);

    // reset in the middle of a packet
    bus.in_valid = 1'b1;
    bus.in_data  = 32'd77;
    tick();
    bus.in_data  = 32'd78;
    tick();
    bus.in_valid = 1'b0;
    rst_n        = 1'b0;
    tick();
    rst_n = 1'b1;
    #1;
    chk("midrst_level", 32'(bus.level),     32'd0);
    chk("midrst_valid", 32'(bus.out_valid), 32'd0);

    // pkt_len=0 (128), changed to 2 at transfer 5
    bus.pkt_len = 7'd0;
    for (int k = 0; k <= 130; k++) begin
      bus.in_valid = (k < 130);
      bus.in_data  = 32'(1000 + k);
      if (k >= 5) bus.pkt_len = 7'd2;
      #1;
      if (k > 0) begin
        chk("p128_data", bus.out_data,      32'(1000 + k - 1));
        chk("p128_last", 32'(bus.out_last), 32'((k == 128) || (k == 130)));
        $display("xfer p128 t=%0d data=%0h last=%0b", k, bus.out_data, bus.out_last);
      end
      tick();
    end
    bus.in_valid = 1'b0;
    bus.pkt_len  = 7'd4;
    #1;
    chk("p128_end_valid", 32'(bus.out_valid), 32'd0);
    chk("p128_end_level", 32'(bus.level),     32'd0);

    // fill with out_ready=0: 514 samples, last two dropped
    bus.out_ready = 1'b0;
    for (int i = 0; i < 514; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = 32'(100 + i);
      tick();
      if (i == 300) chk("fill_hold_data", bus.out_data, 32'd100);
      if (i == 511) begin
        chk("fill_level_512", 32'(bus.level),    32'd512);
        chk("fill_drop_0",    32'(bus.drop_cnt), 32'd0);
      end
    end
    bus.in_valid = 1'b0;
    #1;
    chk("full_level", 32'(bus.level),     32'd512);
    chk("full_drop",  32'(bus.drop_cnt),  32'(DROP_EXP));
    chk("full_data",  bus.out_data,       32'd100);
    chk("full_valid", 32'(bus.out_valid), 32'd1);
    chk("full_last",  32'(bus.out_last),  32'd0);
    $display("step fill level=%0d drop=%0d", bus.level, bus.drop_cnt);

    // write and transfer together at full
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.in_data   = 32'd999;
    #1;
    chk("fullrw_tx", 32'(bus.tx_valid), 32'd1);
    $display("xfer drain t=1 data=%0h last=%0b", bus.out_data, bus.out_last);
    tick();
    bus.in_valid = 1'b0;
    #1;
    chk("fullrw_level", 32'(bus.level),     32'd512);
    chk("fullrw_drop",  32'(bus.drop_cnt),  32'(DROP_EXP));
    chk("fullrw_data",  bus.out_data,       32'd101);
    chk("fullrw_valid", 32'(bus.out_valid), 32'd1);

    // drain: 101..611 then 999, packets of 4
    for (int t = 2; t <= 513; t++) begin
      chk("drain_data", bus.out_data,      (t <= 512) ? 32'(100 + t - 1) : 32'd999);
      chk("drain_last", 32'(bus.out_last), 32'(t % 4 == 0));
      $display("xfer drain t=%0d data=%0h last=%0b", t, bus.out_data, bus.out_last);
      tick();
    end
    chk("drain_end_valid", 32'(bus.out_valid), 32'd0);
    chk("drain_end_level", 32'(bus.level),     32'd0);

    // clear with 10 samples stored and in_valid asserted
    bus.out_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = 32'(50 + i);
      tick();
    end
    bus.in_valid = 1'b0;
    #1;
    chk("clr_pre_level", 32'(bus.level), 32'd10);
    bus.clear     = 1'b1;
    bus.in_valid  = 1'b1;
    bus.in_data   = 32'hDEAD;
    bus.out_ready = 1'b1;
    #1;
    chk("clr_cycle_tx", 32'(bus.tx_valid), 32'd0);
    tick();
    bus.clear    = 1'b0;
    bus.in_valid = 1'b0;
    #1;
    chk("clr_valid", 32'(bus.out_valid), 32'd0);
    chk("clr_level", 32'(bus.level),     32'd0);
    chk("clr_tx",    32'(bus.tx_valid),  32'd0);
    chk("clr_drop",  32'(bus.drop_cnt),  32'(DROP_EXP));

    // packet counter restarts at 0 after clear
    bus.pkt_len  = 7'd1;
    bus.in_valid = 1'b1;
    bus.in_data  = 32'd55;
    tick();
    bus.in_valid = 1'b0;
    #1;
    chk("postclr_data", bus.out_data,      32'd55);
    chk("postclr_last", 32'(bus.out_last), 32'd1);
    $display("xfer postclr data=%0h last=%0b", bus.out_data, bus.out_last);
    tick();
    chk("postclr_level", 32'(bus.level), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
